// File: rtl/interrupt_ack_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pic_pkg : shared types and helpers for the 8259A interrupt-ack path      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } ack_state_e;

  localparam logic [2:0] LOWEST_PRIORITY_RESET = 3'd7;

  function automatic logic [2:0] onehot_to_level(input logic [7:0] onehot);
    logic [2:0] lvl;
    lvl = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (onehot[i]) lvl = 3'(i);
    end
    return lvl;
  endfunction

  function automatic logic [7:0] rotate_right8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] w;
    w = {v, v} >> n;
    return w[7:0];
  endfunction

  function automatic logic [7:0] rotate_left8(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] w;
    w = {v, v} << n;
    return w[15:8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/isr_priority_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | isr_priority_encoder : one-hot highest-priority set ISR bit (rotating)   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module isr_priority_encoder
  import pic_pkg::*;
(
  input  logic [7:0] isr_i,
  input  logic [2:0] priority_rotate_i,
  output logic [7:0] highest_o,
  output logic       found_o
);

  logic [2:0] shift;
  logic [7:0] rotated;
  logic [7:0] lowest;

  // Rotate so the highest-priority level lands on bit 0, isolate the lowest
  // set bit, then rotate back into level positions.
  assign shift     = priority_rotate_i + 3'd1;
  assign rotated   = rotate_right8(isr_i, shift);
  assign lowest    = rotated & (~rotated + 8'd1);
  assign highest_o = rotate_left8(lowest, shift);
  assign found_o   = |isr_i;

endmodule
`default_nettype wire

// File: rtl/interrupt_ack_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | interrupt_ack_controller : INT pin, 8086 INTA sequence, ISR and EOI      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module interrupt_ack_controller
  import pic_pkg::*;
#(
  parameter logic [2:0] SPURIOUS_LEVEL = 3'd7
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] interrupt,
  input  logic       inta_n,
  input  logic [4:0] interrupt_vector_base,
  input  logic       auto_eoi_config,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       eoi_rotate,
  input  logic       set_priority_valid,
  output logic       int_out,
  output logic [7:0] in_service_register,
  output logic [7:0] clear_interrupt_request,
  output logic [7:0] highest_level_in_service,
  output logic [2:0] priority_rotate,
  output logic [7:0] data_out,
  output logic       data_out_enable
);

  ack_state_e state_q, state_d;
  logic       int_out_q, int_out_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] clr_q, clr_d;
  logic [2:0] rot_q, rot_d;
  logic [7:0] dout_q, dout_d;
  logic       doe_q, doe_d;
  logic [2:0] ack_level_q, ack_level_d;
  logic       spurious_q, spurious_d;
  logic       inta_prev_q;

  logic       inta_fall, inta_rise;
  logic [7:0] hl;
  logic       hl_found;
  logic [7:0] eoi_mask, aeoi_mask, set_mask;
  logic [2:0] eoi_lvl;
  logic       eoi_hit;

  assign inta_fall = inta_prev_q & ~inta_n;
  assign inta_rise = ~inta_prev_q & inta_n;

  isr_priority_encoder u_isr_priority_encoder (
    .isr_i             (isr_q),
    .priority_rotate_i (rot_q),
    .highest_o         (hl),
    .found_o           (hl_found)
  );

  always_comb begin
    state_d     = state_q;
    int_out_d   = int_out_q;
    clr_d       = 8'd0;
    rot_d       = rot_q;
    dout_d      = dout_q;
    doe_d       = doe_q;
    ack_level_d = ack_level_q;
    spurious_d  = spurious_q;
    eoi_mask    = 8'd0;
    aeoi_mask   = 8'd0;
    set_mask    = 8'd0;
    eoi_lvl     = eoi_specific ? eoi_level : onehot_to_level(hl);
    eoi_hit     = eoi_specific ? isr_q[eoi_level] : hl_found;

    if (eoi_valid) begin
      eoi_mask = eoi_specific ? (8'd1 << eoi_level) : hl;
      if (eoi_rotate && eoi_hit) rot_d = eoi_lvl;
    end
    if (set_priority_valid) rot_d = eoi_level;

    case (state_q)
      IDLE: begin
        if (interrupt != 8'd0) begin
          state_d   = ACK1;
          int_out_d = 1'b1;
        end
      end
      ACK1: begin
        int_out_d = 1'b1;
        if (inta_fall) begin
          int_out_d = 1'b0;
          state_d   = ACK2;
          if (interrupt == 8'd0) begin
            ack_level_d = SPURIOUS_LEVEL;
            spurious_d  = 1'b1;
          end else begin
            ack_level_d = onehot_to_level(interrupt);
            spurious_d  = 1'b0;
            set_mask    = 8'd1 << onehot_to_level(interrupt);
            clr_d       = set_mask;
          end
        end
      end
      ACK2: begin
        // The first pulse's rising edge also arrives here; only the rise that
        // ends the vector pulse (enable already driven) completes the cycle.
        if (inta_fall) begin
          dout_d = {interrupt_vector_base, ack_level_q};
          doe_d  = 1'b1;
        end else if (inta_rise && doe_q) begin
          doe_d   = 1'b0;
          state_d = IDLE;
          if (auto_eoi_config && !spurious_q) aeoi_mask = 8'd1 << ack_level_q;
        end
      end
      default: state_d = IDLE;
    endcase

    isr_d = (isr_q & ~eoi_mask & ~aeoi_mask) | set_mask;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      int_out_q   <= 1'b0;
      isr_q       <= 8'd0;
      clr_q       <= 8'd0;
      rot_q       <= LOWEST_PRIORITY_RESET;
      dout_q      <= 8'd0;
      doe_q       <= 1'b0;
      ack_level_q <= 3'd0;
      spurious_q  <= 1'b0;
      inta_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      int_out_q   <= int_out_d;
      isr_q       <= isr_d;
      clr_q       <= clr_d;
      rot_q       <= rot_d;
      dout_q      <= dout_d;
      doe_q       <= doe_d;
      ack_level_q <= ack_level_d;
      spurious_q  <= spurious_d;
      inta_prev_q <= inta_n;
    end
  end

  assign int_out                  = int_out_q;
  assign in_service_register      = isr_q;
  assign clear_interrupt_request  = clr_q;
  assign highest_level_in_service = hl;
  assign priority_rotate          = rot_q;
  assign data_out                 = dout_q;
  assign data_out_enable          = doe_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_ack_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_interrupt_ack_controller : self-checking bench with reference model   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_interrupt_ack_controller;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] interrupt;
  logic       inta_n;
  logic [4:0] interrupt_vector_base;
  logic       auto_eoi_config;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       eoi_rotate;
  logic       set_priority_valid;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [7:0] clear_interrupt_request;
  logic [7:0] highest_level_in_service;
  logic [2:0] priority_rotate;
  logic [7:0] data_out;
  logic       data_out_enable;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] m_isr;
  logic [2:0] m_rot;

  always #5 clock = ~clock;

  interrupt_ack_controller dut (
    .clock                    (clock),
    .reset_n                  (reset_n),
    .interrupt                (interrupt),
    .inta_n                   (inta_n),
    .interrupt_vector_base    (interrupt_vector_base),
    .auto_eoi_config          (auto_eoi_config),
    .eoi_valid                (eoi_valid),
    .eoi_specific             (eoi_specific),
    .eoi_level                (eoi_level),
    .eoi_rotate               (eoi_rotate),
    .set_priority_valid       (set_priority_valid),
    .int_out                  (int_out),
    .in_service_register      (in_service_register),
    .clear_interrupt_request  (clear_interrupt_request),
    .highest_level_in_service (highest_level_in_service),
    .priority_rotate          (priority_rotate),
    .data_out                 (data_out),
    .data_out_enable          (data_out_enable)
  );

  // Walk levels from highest to lowest priority: rot+1, rot+2, ..., rot.
  function automatic logic [7:0] model_highest(input logic [7:0] isr, input logic [2:0] rot);
    for (int k = 1; k <= 8; k++) begin
      int lvl;
      lvl = (int'(rot) + k) % 8;
      if (isr[lvl]) return 8'd1 << lvl;
    end
    return 8'd0;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    m_isr = 8'd0;
    m_rot = 3'd7;
  endtask

  // Full INTA sequence for a given request; the request drops once acknowledged.
  task automatic run_ack(input logic [7:0] req);
    interrupt = req;
    tick();
    inta_n = 1'b0;
    tick();
    interrupt = 8'd0;
    tick();
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    inta_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    inta_n = 1'b1;
    do_reset();
    total++; if (int_out !== 1'b0) begin bad++; $display("FAIL reset_int_out: got %b want 0", int_out); end
    total++; if (in_service_register !== 8'h00) begin bad++; $display("FAIL reset_isr: got %h want 00", in_service_register); end
    total++; if (priority_rotate !== 3'd7) begin bad++; $display("FAIL reset_rot: got %0d want 7", priority_rotate); end
    total++; if (data_out_enable !== 1'b0) begin bad++; $display("FAIL reset_doe: got %b want 0", data_out_enable); end
    total++; if (clear_interrupt_request !== 8'h00 || data_out !== 8'h00) begin bad++; $display("FAIL reset_clr_dout: got %h/%h want 00/00", clear_interrupt_request, data_out); end
    total++; if (highest_level_in_service !== 8'h00) begin bad++; $display("FAIL reset_hl: got %h want 00", highest_level_in_service); end
  endtask

  task automatic test_normal_ack(input logic aeoi);
    do_reset();
    auto_eoi_config = aeoi;
    interrupt_vector_base = 5'b01000;
    interrupt = 8'h04;
    tick();
    total++; if (int_out !== 1'b1) begin bad++; $display("FAIL ack_int_out: got %b want 1", int_out); end
    inta_n = 1'b0;
    tick();
    interrupt = 8'h00;
    total++; if (in_service_register !== 8'h04) begin bad++; $display("FAIL ack_isr_set: got %h want 04", in_service_register); end
    total++; if (clear_interrupt_request !== 8'h04) begin bad++; $display("FAIL ack_clr_pulse: got %h want 04", clear_interrupt_request); end
    total++; if (int_out !== 1'b0) begin bad++; $display("FAIL ack_int_drop: got %b want 0", int_out); end
    tick();
    total++; if (clear_interrupt_request !== 8'h00) begin bad++; $display("FAIL ack_clr_one_cycle: got %h want 00", clear_interrupt_request); end
    inta_n = 1'b1;
    tick();
    total++; if (data_out_enable !== 1'b0) begin bad++; $display("FAIL ack_doe_early: got %b want 0", data_out_enable); end
    inta_n = 1'b0;
    tick();
    total++; if (data_out !== 8'h42 || data_out_enable !== 1'b1) begin bad++; $display("FAIL ack_vector: got %h/%b want 42/1", data_out, data_out_enable); end
    tick();
    total++; if (data_out_enable !== 1'b1) begin bad++; $display("FAIL ack_doe_hold: got %b want 1", data_out_enable); end
    inta_n = 1'b1;
    tick();
    total++; if (data_out_enable !== 1'b0) begin bad++; $display("FAIL ack_doe_off: got %b want 0", data_out_enable); end
    total++; if (in_service_register !== (aeoi ? 8'h00 : 8'h04)) begin bad++; $display("FAIL ack_isr_after: got %h want %h", in_service_register, aeoi ? 8'h00 : 8'h04); end
    auto_eoi_config = 1'b0;
  endtask

  task automatic test_nonspecific_eoi();
    do_reset();
    run_ack(8'h02);
    run_ack(8'h10);
    total++; if (in_service_register !== 8'h12) begin bad++; $display("FAIL nse_setup: got %h want 12", in_service_register); end
    eoi_valid = 1'b1; eoi_specific = 1'b0; eoi_rotate = 1'b1;
    tick();
    eoi_valid = 1'b0; eoi_rotate = 1'b0;
    total++; if (in_service_register !== 8'h10) begin bad++; $display("FAIL nse_isr: got %h want 10", in_service_register); end
    total++; if (priority_rotate !== 3'd1) begin bad++; $display("FAIL nse_rot: got %0d want 1", priority_rotate); end
    total++; if (highest_level_in_service !== 8'h10) begin bad++; $display("FAIL nse_hl: got %h want 10", highest_level_in_service); end
  endtask

  task automatic test_spurious();
    do_reset();
    interrupt_vector_base = 5'b01000;
    interrupt = 8'h08;
    tick();
    interrupt = 8'h00;
    tick();
    total++; if (int_out !== 1'b1) begin bad++; $display("FAIL spur_int_hold: got %b want 1", int_out); end
    inta_n = 1'b0;
    tick();
    total++; if (in_service_register !== 8'h00 || clear_interrupt_request !== 8'h00) begin bad++; $display("FAIL spur_no_ack: got %h/%h want 00/00", in_service_register, clear_interrupt_request); end
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    total++; if (data_out !== 8'h47 || data_out_enable !== 1'b1) begin bad++; $display("FAIL spur_vector: got %h/%b want 47/1", data_out, data_out_enable); end
    inta_n = 1'b1;
    tick();
    total++; if (in_service_register !== 8'h00 || data_out_enable !== 1'b0) begin bad++; $display("FAIL spur_end: got %h/%b want 00/0", in_service_register, data_out_enable); end
  endtask

  task automatic test_collision();
    do_reset();
    run_ack(8'h08);
    interrupt = 8'h20;
    tick();
    inta_n = 1'b0;
    eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd3;
    tick();
    eoi_valid = 1'b0; eoi_specific = 1'b0; interrupt = 8'h00;
    total++; if (in_service_register !== 8'h20) begin bad++; $display("FAIL coll_isr: got %h want 20", in_service_register); end
    total++; if (clear_interrupt_request !== 8'h20) begin bad++; $display("FAIL coll_clr: got %h want 20", clear_interrupt_request); end
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    tick();
    total++; if (data_out_enable !== 1'b1) begin bad++; $display("FAIL coll_doe: got %b want 1", data_out_enable); end
    // Reset in the middle of the vector pulse
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    total++; if (data_out_enable !== 1'b0 || in_service_register !== 8'h00 || int_out !== 1'b0) begin bad++; $display("FAIL midreset: got doe=%b isr=%h int=%b want 0/00/0", data_out_enable, in_service_register, int_out); end
    inta_n = 1'b1;
    tick();
    total++; if (data_out_enable !== 1'b0) begin bad++; $display("FAIL midreset_doe: got %b want 0", data_out_enable); end
    interrupt = 8'h01;
    tick();
    interrupt = 8'h00;
    total++; if (int_out !== 1'b1) begin bad++; $display("FAIL midreset_idle: got %b want 1", int_out); end
    do_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        logic [2:0] lvl;
        logic       aeoi;
        logic [4:0] base;
        lvl  = 3'($urandom_range(0, 7));
        aeoi = 1'($urandom_range(0, 1));
        base = 5'($urandom);
        auto_eoi_config = aeoi;
        interrupt_vector_base = base;
        interrupt = 8'd1 << lvl;
        tick();
        inta_n = 1'b0;
        tick();
        interrupt = 8'h00;
        inta_n = 1'b1;
        tick();
        inta_n = 1'b0;
        tick();
        total++; if (data_out !== {base, lvl} || data_out_enable !== 1'b1) begin bad++; $display("FAIL rnd_vector: got %h/%b want %h/1", data_out, data_out_enable, {base, lvl}); end
        inta_n = 1'b1;
        tick();
        auto_eoi_config = 1'b0;
        m_isr[lvl] = 1'b1;
        if (aeoi) m_isr[lvl] = 1'b0;
      end else begin
        logic       spec, rot, setp;
        logic [2:0] lvl;
        logic [7:0] h;
        spec = 1'($urandom_range(0, 1));
        rot  = 1'($urandom_range(0, 1));
        lvl  = 3'($urandom_range(0, 7));
        setp = (op == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        eoi_valid = 1'b1; eoi_specific = spec; eoi_rotate = rot; eoi_level = lvl;
        set_priority_valid = setp;
        tick();
        eoi_valid = 1'b0; eoi_specific = 1'b0; eoi_rotate = 1'b0; set_priority_valid = 1'b0;
        if (spec) begin
          if (m_isr[lvl]) begin
            m_isr[lvl] = 1'b0;
            if (rot) m_rot = lvl;
          end
        end else begin
          h = model_highest(m_isr, m_rot);
          for (int b = 0; b < 8; b++) begin
            if (h[b]) begin
              m_isr[b] = 1'b0;
              if (rot) m_rot = 3'(b);
            end
          end
        end
        if (setp) m_rot = lvl;
      end
      total++; if (in_service_register !== m_isr) begin bad++; $display("FAIL rnd_isr: got %h want %h", in_service_register, m_isr); end
      total++; if (priority_rotate !== m_rot) begin bad++; $display("FAIL rnd_rot: got %0d want %0d", priority_rotate, m_rot); end
      total++; if (highest_level_in_service !== model_highest(m_isr, m_rot)) begin bad++; $display("FAIL rnd_hl: got %h want %h", highest_level_in_service, model_highest(m_isr, m_rot)); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    interrupt = 8'h00;
    inta_n = 1'b1;
    interrupt_vector_base = 5'd0;
    auto_eoi_config = 1'b0;
    eoi_valid = 1'b0;
    eoi_specific = 1'b0;
    eoi_level = 3'd0;
    eoi_rotate = 1'b0;
    set_priority_valid = 1'b0;
    m_isr = 8'd0;
    m_rot = 3'd7;
    test_reset();
    test_normal_ack(1'b0);
    test_normal_ack(1'b1);
    test_nonspecific_eoi();
    test_spurious();
    test_collision();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_ack_controller.md
Name: interrupt_ack_controller

Overview:
Control-side counterpart to the priority resolver in the 8259A core. It consumes the resolver's one-hot `interrupt` request and drives the INT pin. It runs the 8086-mode two-pulse INTA sequence and owns the in-service register (ISR), which feeds back to the resolver. It also handles EOI/rotation commands and owns `priority_rotate` and `highest_level_in_service`.

Parameters:
SPURIOUS_LEVEL, 3'd7, level whose vector is returned when no request remains at the first INTA.

Ports:
clock  in  1  system clock
reset_n  in  1  synchronous reset, active-low
interrupt  in  8  one-hot winner from priority resolver (0 = none)
inta_n  in  1  interrupt acknowledge, already synchronised to clock
interrupt_vector_base  in  5  ICW2 T7..T3
auto_eoi_config  in  1  AEOI mode
eoi_valid  in  1  one-cycle EOI command strobe
eoi_specific  in  1  1 = specific EOI, 0 = non-specific
eoi_level  in  3  level for specific EOI
eoi_rotate  in  1  rotate priority on this EOI
set_priority_valid  in  1  one-cycle set-priority strobe (level on eoi_level)
int_out  out  1  INT pin
in_service_register  out  8  ISR
clear_interrupt_request  out  8  one-cycle pulse, clears IRR bit
highest_level_in_service  out  8  one-hot, highest-priority set ISR bit
priority_rotate  out  3  current lowest-priority level
data_out  out  8  vector byte
data_out_enable  out  1  drive data bus

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE, int_out=0, ISR=0, clear_interrupt_request=0, priority_rotate=3'd7, data_out=0, data_out_enable=0. Reset applies mid-sequence too: abort to IDLE with no ISR change beyond the reset.
- Edge detect: inta_prev register, reset to 1. fall = inta_prev & ~inta_n; rise = ~inta_prev & inta_n.
- Priority order: level (priority_rotate+1) mod 8 is highest, priority_rotate is lowest. Wrap-around uses 3-bit arithmetic.
- States:
  - IDLE: interrupt != 0 -> ACK1, and int_out=1 from the next cycle. INTA edges in IDLE are ignored.
  - ACK1: int_out held at 1 even if `interrupt` drops. On fall:
    - latch ack_level = encode(interrupt), set ISR[ack_level], pulse clear_interrupt_request[ack_level] for one cycle, int_out=0, go to ACK2.
    - If interrupt==0 at the fall (spurious): ack_level=SPURIOUS_LEVEL, no ISR set, no clear pulse.
  - ACK2: on fall, data_out={interrupt_vector_base, ack_level} and data_out_enable=1 from the next cycle while inta_n stays low. On rise, data_out_enable=0; if auto_eoi_config=1 and the ack was not spurious, clear ISR[ack_level]. Then return to IDLE (re-arms if interrupt != 0).
- EOI (eoi_valid, any state):
  - Specific: clear ISR[eoi_level].
  - Non-specific: clear the highest-priority set ISR bit; no-op if ISR==0.
  - If eoi_rotate=1 and a bit was cleared, priority_rotate <= cleared level.
- set_priority_valid: priority_rotate <= eoi_level. If asserted with eoi_valid, set-priority wins for priority_rotate.
- Same-cycle ISR update order: EOI clear, then AEOI clear, then ACK1 set. If all target the same bit, set wins.
- highest_level_in_service: combinational from the registered ISR and priority_rotate; 0 when ISR==0.
- All outputs except highest_level_in_service are registered.
- Latency: interrupt -> int_out is 1 cycle; INTA fall -> ISR/clear pulse/data_out_enable is 1 cycle.

Decomposition:
- Shared package (pic_pkg): state enum {IDLE, ACK1, ACK2}, constant LOWEST_PRIORITY_RESET=3'd7, functions onehot_to_level and rotate_left8/rotate_right8.
- One sub-module, isr_priority_encoder: inputs ISR and priority_rotate; outputs one-hot highest bit plus a found flag. Used for both non-specific EOI and highest_level_in_service.

Test Plan:
- Reset: hold reset_n=0 for one cycle with inta_n=1 -> int_out=0, ISR=8'h00, priority_rotate=3'd7, data_out_enable=0.
- Normal ack: interrupt=8'h04, base=5'b01000 -> int_out=1 after 1 cycle.
  - First INTA fall -> ISR=8'h04, clear_interrupt_request=8'h04 for exactly 1 cycle, int_out=0.
  - Second INTA low -> data_out=8'h42, data_out_enable=1; after rise, enable=0 and ISR stays 8'h04.
- AEOI: repeat the normal ack with auto_eoi_config=1 -> ISR=8'h00 one cycle after the second INTA rise.
- Non-specific EOI with rotate: ISR=8'h12, priority_rotate=7, eoi_valid with eoi_specific=0, eoi_rotate=1 -> ISR=8'h10, priority_rotate=3'd1, highest_level_in_service=8'h10.
- Spurious: interrupt=8'h08 raises int_out, then interrupt=0 before the first INTA -> ISR=8'h00, no clear pulse, vector=8'h47 (base 5'b01000).
- Collisions and reset:
  - ISR=8'h08, specific EOI level 3 in the same cycle as the first INTA acking level 5 -> ISR=8'h20.
  - reset_n=0 during ACK2 with inta_n low -> data_out_enable=0, state IDLE, ISR=8'h00.
